// File: rtl/stepper_pkg.sv
// Shared types and character codes for the UART-driven stepper command controller.
package stepper_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_CONT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [7:0] CMD_START = 8'h33;  // '3'
    localparam logic [7:0] CMD_STOP  = 8'h34;  // '4'
    localparam logic [7:0] CMD_CONT  = 8'h76;  // 'v'
    localparam logic [7:0] CMD_FWD   = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_REV   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_A     = 8'h41;
    localparam logic [7:0] CMD_B     = 8'h42;
    localparam logic [7:0] CMD_C     = 8'h43;
    localparam logic [7:0] CMD_D     = 8'h44;
    localparam logic [7:0] CMD_E     = 8'h45;
    localparam logic [7:0] CMD_F     = 8'h46;
    localparam logic [7:0] CMD_G     = 8'h47;
    localparam logic [7:0] CMD_H     = 8'h48;

    localparam logic [7:0] ST_DONE   = 8'h4B;  // 'K'
    localparam logic [7:0] ST_ABORT  = 8'h58;  // 'X'

    function automatic logic is_active(input state_e s);
        return (s == S_RUN) || (s == S_CONT);
    endfunction

    function automatic logic is_unit_cmd(input logic [7:0] b);
        return (b >= CMD_A) && (b <= CMD_H);
    endfunction

endpackage

// File: rtl/step_pulse_timer.sv
// Free-running step pulse generator: one PULSE_CYCLES-wide pulse every PERIOD cycles
// while run is high; clear restarts the period and forces step low.
module step_pulse_timer #(
    parameter int PERIOD       = 10,
    parameter int PULSE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic step,
    output logic rise,
    output logic wrap
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] HIGH_END = CNT_W'(PULSE_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d  = cnt_q;
        step_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            step_d = (cnt_q < HIGH_END);
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    // Strobes describe the cycle before the corresponding step edge.
    assign rise = run && (cnt_q == '0);
    assign wrap = run && (cnt_q == LAST);
    assign step = step_q;

endmodule

// File: rtl/stepper_cmd_ctrl.sv
// Decodes single-character UART commands into counted or continuous step pulse trains.
// Define STEP_STATUS_EN to emit 'K'/'X' status bytes on tx_data/tx_data_en.
module stepper_cmd_ctrl
    import stepper_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int STEP_HZ        = 500,
    parameter int PULSE_CYCLES   = 100,
    parameter int STEPS_PER_UNIT = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_en,
    input  logic       btn_n,
    output logic       step,
    output logic       dir,
    output logic       enable,
    output logic       busy,
    output logic       done,
    output logic [7:0] tx_data,
    output logic       tx_data_en
);

    localparam int PERIOD = CLK_HZ / STEP_HZ;

    state_e      state_q, state_d;
    logic [15:0] target_q, target_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic        dir_q, dir_d;
    logic        enable_q, enable_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        btn_meta_q, btn_sync_q;

    logic        abort, cmd_valid;
    logic [15:0] unit_target;
    logic        tmr_clear, tmr_run, tmr_rise, tmr_wrap;

    // Stop button idles high, so the synchroniser resets to "not pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
        end else begin
            btn_meta_q <= btn_n;
            btn_sync_q <= btn_meta_q;
        end
    end

    assign abort       = ~btn_sync_q | (rx_data_en && (rx_data == CMD_STOP));
    assign cmd_valid   = rx_data_en & ~abort;
    // 'A'..'H' carry 1..8 in their low nibble.
    assign unit_target = 16'(32'(rx_data[3:0]) * 32'(STEPS_PER_UNIT));

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (is_unit_cmd(rx_data)) begin
                        target_d = unit_target;
                    end else begin
                        case (rx_data)
                            CMD_FWD:   dir_d = 1'b1;
                            CMD_REV:   dir_d = 1'b0;
                            CMD_START: if (target_q != '0) state_d = S_RUN;
                            CMD_CONT:  state_d = S_CONT;
                            default:   ;
                        endcase
                    end
                end
            end
            S_RUN:   if (tmr_wrap && (step_cnt_q == target_q)) state_d = S_DONE;
            S_CONT:  ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Timer only counts while the machine stays active; entry and exit both restart it.
    assign tmr_run   = is_active(state_q);
    assign tmr_clear = ~(is_active(state_q) & is_active(state_d));

    step_pulse_timer #(
        .PERIOD       (PERIOD),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tmr_clear),
        .run   (tmr_run),
        .step  (step),
        .rise  (tmr_rise),
        .wrap  (tmr_wrap)
    );

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (tmr_clear) begin
            step_cnt_d = '0;
        end else if (tmr_rise && (step_cnt_q != 16'hFFFF)) begin
            step_cnt_d = step_cnt_q + 16'd1;
        end
        enable_d = ~is_active(state_d);
        busy_d   = is_active(state_d);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            step_cnt_q <= '0;
            dir_q      <= 1'b0;
            enable_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            step_cnt_q <= step_cnt_d;
            dir_q      <= dir_d;
            enable_q   <= enable_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dir    = dir_q;
    assign enable = enable_q;
    assign busy   = busy_q;
    assign done   = done_q;

`ifdef STEP_STATUS_EN
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_en_q, tx_en_d;

    always_comb begin
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        if (abort && is_active(state_q)) begin
            tx_data_d = ST_ABORT;
            tx_en_d   = 1'b1;
        end else if (state_d == S_DONE) begin
            tx_data_d = ST_DONE;
            tx_en_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_data_en = tx_en_q;
`else
    assign tx_data    = 8'h00;
    assign tx_data_en = 1'b0;
`endif

endmodule
